// File: rtl/uart_tx_fifo.sv
// UART transmitter with a built-in transmit FIFO; characters are sent LSB-first, frames back-to-back.
// Optional parity bit after the data bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                     txclk,
    input  logic                     reset,
    input  logic                     ld_tx_data,
    input  logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_enable,
    input  logic                     clr_over_run,
    output logic                     tx_out,
    output logic                     tx_empty,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic                     tx_busy,
    output logic                     tx_over_run
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
    } state_e;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [CW-1:0]       baud_q, baud_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                empty_q, full_q, over_run_q, over_run_d;
    logic                tx_out_q, tx_out_d, busy_q, busy_d;
    logic                push_s, pop_s, baud_end_s;
    logic [DATA_W-1:0]   head_s;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    assign head_s     = mem[rd_ptr_q];
    assign baud_end_s = (baud_q == BAUD_LAST);
    assign push_s     = ld_tx_data && !full_q;

    // FSM state register
    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, bit/shift sequencing and FIFO pop request
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_enable && !empty_q) begin
                    pop_s   = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end_s) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Final stop-bit cycle chains straight into the next start bit when data waits
                if (baud_end_s && (bit_q == STOP_LAST)) begin
                    bit_d = '0;
                    if (tx_enable && !empty_q) begin
                        pop_s   = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (baud_end_s) begin
                    bit_d = bit_q + BW'(1);
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (pop_s) begin
            shift_d = head_s;
        end else begin
            shift_d = shift_d;
        end
    end

    // FSM outputs and baud counter, computed from the next state so they register alongside it
    always_comb begin
        busy_d = (state_d != S_IDLE);
        if ((state_q == S_IDLE) || (state_d != state_q) || baud_end_s) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + CW'(1);
        end
`ifdef UART_TX_PARITY_EN
        par_d = pop_s ? parity_of(head_s) : par_q;
`endif
        case (state_d)
            S_IDLE:   tx_out_d = 1'b1;
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_out_d = par_d;
`endif
            S_STOP:   tx_out_d = 1'b1;
            default:  tx_out_d = 1'b1;
        endcase
    end

    // FIFO pointer, level and over-run bookkeeping; a write into a full FIFO is dropped even on a pop
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (ld_tx_data && full_q) begin
            over_run_d = 1'b1;
        end else if (clr_over_run) begin
            over_run_d = 1'b0;
        end else begin
            over_run_d = over_run_q;
        end
    end

    // FIFO storage
    always_ff @(posedge txclk) begin
        if (push_s) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge txclk) begin
        if (reset) begin
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            over_run_q <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == LVL_FULL);
            over_run_q <= over_run_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx_out      = tx_out_q;
    assign tx_empty    = empty_q;
    assign tx_full     = full_q;
    assign tx_level    = level_q;
    assign tx_busy     = busy_q;
    assign tx_over_run = over_run_q;
endmodule
